// File: rtl/dpram_port_arbiter.sv
// Shares one dual-port synchronous RAM between two clients: an independent
// round-robin arbiter on the write port and one on the read port.
module dpram_port_arbiter #(
    parameter int ram_width = 8,
    parameter int addr_size = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 c0_wr_req,
    input  logic [addr_size-1:0] c0_wr_addr,
    input  logic [ram_width-1:0] c0_wr_data,
    output logic                 c0_wr_gnt,
    input  logic                 c1_wr_req,
    input  logic [addr_size-1:0] c1_wr_addr,
    input  logic [ram_width-1:0] c1_wr_data,
    output logic                 c1_wr_gnt,
    input  logic                 c0_rd_req,
    input  logic [addr_size-1:0] c0_rd_addr,
    output logic                 c0_rd_gnt,
    output logic                 c0_rd_valid,
    input  logic                 c1_rd_req,
    input  logic [addr_size-1:0] c1_rd_addr,
    output logic                 c1_rd_gnt,
    output logic                 c1_rd_valid,
    output logic [ram_width-1:0] rd_data,
    output logic                 ram_write_en,
    output logic [addr_size-1:0] ram_wr_addr,
    output logic [ram_width-1:0] ram_data_in,
    output logic                 ram_read_en,
    output logic [addr_size-1:0] ram_rd_addr,
    input  logic [ram_width-1:0] ram_data_out
);

    // Handshake: a request is held with stable fields until its gnt is high
    // at a rising edge; the transfer (write commit / read address capture)
    // happens at that edge. Dropping req before gnt withdraws it.

    // pri names the client that wins when both request (0 = client 0).
    logic wr_pri_q, wr_pri_d;
    logic rd_pri_q, rd_pri_d;
    logic c0_rd_valid_q, c1_rd_valid_q;

    always_comb begin
        c0_wr_gnt = 1'b0;
        c1_wr_gnt = 1'b0;
        if (!reset) begin
            if (c0_wr_req && (!c1_wr_req || !wr_pri_q)) begin
                c0_wr_gnt = 1'b1;
            end else if (c1_wr_req) begin
                c1_wr_gnt = 1'b1;
            end
        end
        wr_pri_d = wr_pri_q;
        if (c0_wr_gnt) begin
            wr_pri_d = 1'b1;
        end else if (c1_wr_gnt) begin
            wr_pri_d = 1'b0;
        end
    end

    always_comb begin
        c0_rd_gnt = 1'b0;
        c1_rd_gnt = 1'b0;
        if (!reset) begin
            if (c0_rd_req && (!c1_rd_req || !rd_pri_q)) begin
                c0_rd_gnt = 1'b1;
            end else if (c1_rd_req) begin
                c1_rd_gnt = 1'b1;
            end
        end
        rd_pri_d = rd_pri_q;
        if (c0_rd_gnt) begin
            rd_pri_d = 1'b1;
        end else if (c1_rd_gnt) begin
            rd_pri_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_pri_q      <= 1'b0;
            rd_pri_q      <= 1'b0;
            c0_rd_valid_q <= 1'b0;
            c1_rd_valid_q <= 1'b0;
        end else begin
            wr_pri_q      <= wr_pri_d;
            rd_pri_q      <= rd_pri_d;
            c0_rd_valid_q <= c0_rd_gnt;
            c1_rd_valid_q <= c1_rd_gnt;
        end
    end

    // RAM fields default to client 0 when the port is idle.
    assign ram_write_en = c0_wr_gnt | c1_wr_gnt;
    assign ram_wr_addr  = c1_wr_gnt ? c1_wr_addr : c0_wr_addr;
    assign ram_data_in  = c1_wr_gnt ? c1_wr_data : c0_wr_data;
    assign ram_read_en  = c0_rd_gnt | c1_rd_gnt;
    assign ram_rd_addr  = c1_rd_gnt ? c1_rd_addr : c0_rd_addr;

    // Masking with reset drops a read return that lands in a reset cycle.
    assign c0_rd_valid = c0_rd_valid_q & ~reset;
    assign c1_rd_valid = c1_rd_valid_q & ~reset;
    assign rd_data     = ram_data_out;

endmodule
